// File: rtl/lat_comp_pkg.sv
// Shared constants and helpers for the latency-compensation FIFO.
package lat_comp_pkg;

    localparam int DATA_WIDTH_DEF   = 16;
    localparam int PIPE_LATENCY_MIN = 1;
    localparam int PIPE_LATENCY_MAX = 16;

    // Bits needed to hold a count of 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lat_comp_fifo_mem.sv
// Storage array for lat_comp_fifo: one synchronous write port, one asynchronous read port.
module lat_comp_fifo_mem
    import lat_comp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [PTR_W-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lat_comp_fifo.sv
// Credit-based skid FIFO behind a fixed-latency, non-stallable pipeline.
// Optional sticky overflow flag ovf_err when LAT_COMP_FIFO_OVF_EN is defined.
module lat_comp_fifo
    import lat_comp_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int PIPE_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_fire,
    output logic                  issue_ok,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
`ifdef LAT_COMP_FIFO_OVF_EN
    ,
    output logic                  ovf_err
`endif
);

    localparam int DEPTH = PIPE_LATENCY + 1;
    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    if (PIPE_LATENCY < PIPE_LATENCY_MIN || PIPE_LATENCY > PIPE_LATENCY_MAX) begin : g_bad_latency
        $error("lat_comp_fifo: PIPE_LATENCY out of range");
    end

    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] infl;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W:0]   credit_used;
    logic             issue_acc;
    logic             xfer;
    logic             wr_en;
    logic             drop;

    // Handshakes: an output transfer happens on a cycle where out_valid && out_ready;
    // out_valid never depends on out_ready. The input side has no backpressure, so
    // upstream must only launch (issue_fire) while issue_ok, which reserves a slot
    // for every item in flight so a legal stream never overflows.
    assign credit_used = {1'b0, occ} + {1'b0, infl};
    assign issue_ok    = credit_used < {1'b0, DEPTH_C};
    assign issue_acc   = issue_fire && issue_ok;
    assign out_valid   = (occ != '0);
    assign xfer        = out_valid && out_ready;
    assign wr_en       = in_valid && ((occ != DEPTH_C) || xfer);
    assign drop        = in_valid && !wr_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ    <= '0;
            infl   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            // An arrival with nothing in flight is not counted down, so infl cannot wrap.
            if (issue_acc && !in_valid) begin
                infl <= infl + CNT_W'(1);
            end else if (!issue_acc && in_valid && (infl != '0)) begin
                infl <= infl - CNT_W'(1);
            end

            if (wr_en && !xfer) begin
                occ <= occ + CNT_W'(1);
            end else if (xfer && !wr_en) begin
                occ <= occ - CNT_W'(1);
            end

            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (xfer) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

`ifdef LAT_COMP_FIFO_OVF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_err <= 1'b0;
        end else if (drop || (issue_fire && !issue_ok)) begin
            ovf_err <= 1'b1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

    lat_comp_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_addr (rd_ptr),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_lat_comp_fifo.sv
// Directed bench for lat_comp_fifo (DATA_WIDTH=16, PIPE_LATENCY=3, DEPTH=4).
module tb_lat_comp_fifo;

    logic        clk;
    logic        reset;
    logic        issue_fire;
    logic        issue_ok;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
`ifdef LAT_COMP_FIFO_OVF_EN
    logic        ovf_err;
`endif

    int n_vec;
    int n_err;

    lat_comp_fifo #(.DATA_WIDTH(16), .PIPE_LATENCY(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .issue_fire (issue_fire),
        .issue_ok   (issue_ok),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
`ifdef LAT_COMP_FIFO_OVF_EN
        ,
        .ovf_err    (ovf_err)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs drive after the falling edge; expected values describe the
    // registered state seen during that cycle, before the next rising edge.
    typedef struct {
        logic        fire;
        logic        iv;
        logic [15:0] din;
        logic        rdy;
        logic        e_ok;
        logic        e_ov;
        logic [15:0] e_dout;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fire, input logic iv, input logic [15:0] din, input logic rdy);
        issue_fire = fire;
        in_valid   = iv;
        in_data    = din;
        out_ready  = rdy;
    endtask

    task automatic add(input logic fire, input logic iv, input logic [15:0] din, input logic rdy,
                       input logic e_ok, input logic e_ov, input logic [15:0] e_dout, input logic e_ovf);
        vec_t v;
        v.fire = fire; v.iv = iv; v.din = din; v.rdy = rdy;
        v.e_ok = e_ok; v.e_ov = e_ov; v.e_dout = e_dout; v.e_ovf = e_ovf;
        vecs.push_back(v);
    endtask

    initial begin
        int got;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 1'b0);

        //   fire iv  din      rdy  ok  ov  dout     ovf
        // empty pass-through
        add(0, 0, 16'h0000, 0,   1, 0, 16'h0000, 0);
        add(0, 1, 16'hABCD, 1,   1, 0, 16'h0000, 0);
        add(0, 0, 16'h0000, 1,   1, 1, 16'hABCD, 0);
        add(0, 0, 16'h0000, 1,   1, 0, 16'h0000, 0);
        // credit exhaustion then in-order drain
        add(1, 0, 16'h0000, 0,   1, 0, 16'h0000, 0);
        add(1, 0, 16'h0000, 0,   1, 0, 16'h0000, 0);
        add(1, 0, 16'h0000, 0,   1, 0, 16'h0000, 0);
        add(1, 0, 16'h0000, 0,   1, 0, 16'h0000, 0);
        add(0, 1, 16'h0001, 0,   0, 0, 16'h0000, 0);
        add(0, 1, 16'h0002, 0,   0, 1, 16'h0001, 0);
        add(0, 1, 16'h0003, 0,   0, 1, 16'h0001, 0);
        add(0, 1, 16'h0004, 0,   0, 1, 16'h0001, 0);
        add(0, 0, 16'h0000, 1,   0, 1, 16'h0001, 0);
        add(0, 0, 16'h0000, 1,   1, 1, 16'h0002, 0);
        add(0, 0, 16'h0000, 1,   1, 1, 16'h0003, 0);
        add(0, 0, 16'h0000, 1,   1, 1, 16'h0004, 0);
        add(0, 0, 16'h0000, 0,   1, 0, 16'h0000, 0);
        // full with simultaneous write and transfer
        add(0, 1, 16'h0011, 0,   1, 0, 16'h0000, 0);
        add(0, 1, 16'h0012, 0,   1, 1, 16'h0011, 0);
        add(0, 1, 16'h0013, 0,   1, 1, 16'h0011, 0);
        add(0, 1, 16'h0014, 0,   1, 1, 16'h0011, 0);
        add(0, 1, 16'h0055, 1,   0, 1, 16'h0011, 0);
        add(0, 0, 16'h0000, 1,   0, 1, 16'h0012, 0);
        add(0, 0, 16'h0000, 1,   1, 1, 16'h0013, 0);
        add(0, 0, 16'h0000, 1,   1, 1, 16'h0014, 0);
        add(0, 0, 16'h0000, 1,   1, 1, 16'h0055, 0);
        add(0, 0, 16'h0000, 0,   1, 0, 16'h0000, 0);
        // overflow: 0xDEAD arrives while full and stalled
        add(0, 1, 16'h0021, 0,   1, 0, 16'h0000, 0);
        add(0, 1, 16'h0022, 0,   1, 1, 16'h0021, 0);
        add(0, 1, 16'h0023, 0,   1, 1, 16'h0021, 0);
        add(0, 1, 16'h0024, 0,   1, 1, 16'h0021, 0);
        add(0, 1, 16'hDEAD, 0,   0, 1, 16'h0021, 0);
        add(0, 0, 16'h0000, 1,   0, 1, 16'h0021, 1);
        add(0, 0, 16'h0000, 1,   1, 1, 16'h0022, 1);
        add(0, 0, 16'h0000, 1,   1, 1, 16'h0023, 1);
        add(0, 0, 16'h0000, 1,   1, 1, 16'h0024, 1);
        add(0, 0, 16'h0000, 0,   1, 0, 16'h0000, 1);

        repeat (2) @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].fire, vecs[i].iv, vecs[i].din, vecs[i].rdy);
            #1;
            check($sformatf("v%0d issue_ok", i), {15'd0, issue_ok}, {15'd0, vecs[i].e_ok});
            check($sformatf("v%0d out_valid", i), {15'd0, out_valid}, {15'd0, vecs[i].e_ov});
            if (vecs[i].e_ov) begin
                check($sformatf("v%0d out_data", i), out_data, vecs[i].e_dout);
            end
`ifdef LAT_COMP_FIFO_OVF_EN
            check($sformatf("v%0d ovf_err", i), {15'd0, ovf_err}, {15'd0, vecs[i].e_ovf});
`endif
        end

        // Pointer wrap: 10 items at full rate through a 4-entry buffer.
        got = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i < 10) drive(1'b0, 1'b1, 16'h0100 + 16'(i), 1'b1);
            else        drive(1'b0, 1'b0, 16'h0000, 1'b1);
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("wrap unexpected out_valid", {15'd0, out_valid}, 16'h0000);
                end else begin
                    check($sformatf("wrap item %0d", got), out_data, exp_q.pop_front());
                    got++;
                end
            end
            if (i < 10) exp_q.push_back(16'h0100 + 16'(i));
        end
        check("wrap item count", 16'(got), 16'd10);
        check("wrap queue empty", 16'(exp_q.size()), 16'd0);

        // Reset mid-stream with occ=2, infl=1.
        @(negedge clk); drive(1'b0, 1'b1, 16'h0A01, 1'b0);
        @(negedge clk); drive(1'b0, 1'b1, 16'h0A02, 1'b0);
        @(negedge clk); drive(1'b1, 1'b0, 16'h0000, 1'b0);
        @(negedge clk); drive(1'b0, 1'b0, 16'h0000, 1'b0);
        #1;
        check("pre-reset out_valid", {15'd0, out_valid}, 16'h0001);
        check("pre-reset out_data", out_data, 16'h0A01);
        reset = 1'b1;
        #1;
        check("async reset out_valid", {15'd0, out_valid}, 16'h0000);
        check("async reset issue_ok", {15'd0, issue_ok}, 16'h0001);
`ifdef LAT_COMP_FIFO_OVF_EN
        check("async reset ovf_err", {15'd0, ovf_err}, 16'h0000);
`endif
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b1, 16'h0B0B, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        #1;
        check("post-reset out_valid", {15'd0, out_valid}, 16'h0001);
        check("post-reset out_data", out_data, 16'h0B0B);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        #1;
        check("post-reset drained", {15'd0, out_valid}, 16'h0000);
        check("post-reset issue_ok", {15'd0, issue_ok}, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lat_comp_fifo.md
LAT_COMP_FIFO -- requirements
Module: lat_comp_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the payload width in bits.
REQ-002 SHALL have parameter PIPE_LATENCY, default 3, the fixed cycle latency of the upstream non-stallable pipeline (legal range 1..16).
REQ-003 SHALL derive localparam DEPTH = PIPE_LATENCY+1 and CNT_W = $clog2(DEPTH+1).
REQ-004 SHALL have port clk, input, 1, clock (rising edge).
REQ-005 SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port issue_fire, input, 1, upstream launched one item into the pipeline this cycle.
REQ-007 SHALL have port issue_ok, output, 1, upstream may launch an item this cycle.
REQ-008 SHALL have port in_valid, input, 1, item arrives from the pipeline exit (no backpressure possible).
REQ-009 SHALL have port in_data, input, DATA_WIDTH, arriving payload.
REQ-010 SHALL have port out_valid, output, 1, buffered item available.
REQ-011 SHALL have port out_data, output, DATA_WIDTH, oldest buffered item.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts; a transfer occurs when out_valid and out_ready are both 1.

Function
REQ-013 SHALL keep occ (stored items, 0..DEPTH) and infl (issued, not yet arrived, 0..DEPTH), both CNT_W-bit registers.
REQ-014 SHALL drive issue_ok = (occ + infl) < DEPTH, combinational from registers only (no path from issue_fire or out_ready).
REQ-015 SHALL update infl by +1 on issue_fire, -1 on in_valid; both in one cycle leaves infl unchanged.
REQ-016 SHALL ignore issue_fire when issue_ok=0 (protocol violation, infl unchanged).
REQ-017 SHALL write in_data at wr_ptr on in_valid if occ<DEPTH, or if occ=DEPTH and a transfer happens in the same cycle.
REQ-018 SHALL drop in_valid data when occ=DEPTH and no transfer in that cycle.
REQ-019 SHALL be first-word-fall-through: out_valid = (occ!=0), out_data = mem[rd_ptr]; no bypass, so data written in cycle n is visible in cycle n+1.
REQ-020 SHALL wrap rd_ptr/wr_ptr from DEPTH-1 to 0.
REQ-021 SHALL leave occ unchanged on a simultaneous write and transfer.
REQ-022 SHALL preserve arrival order exactly, with no duplication.

Reset
REQ-023 SHALL on reset clear occ, infl, rd_ptr and wr_ptr, giving out_valid=0 and issue_ok=1; storage contents are not reset.
REQ-024 SHALL on reset mid-operation discard all stored and in-flight items; items arriving after reset release are written normally.

Configuration
REQ-025 SHALL with macro LAT_COMP_FIFO_OVF_EN defined add output ovf_err (1 bit), set sticky in the cycle after any REQ-018 drop or REQ-016 violation, cleared only by reset.
REQ-026 SHALL without LAT_COMP_FIFO_OVF_EN omit the ovf_err port, with drops and violations silent and all other behaviour identical.

Structure
REQ-027 SHALL place the DATA_WIDTH default, the PIPE_LATENCY range limit and a counter-width function in shared package lat_comp_pkg.
REQ-028 SHALL implement storage as sub-module lat_comp_fifo_mem (DEPTH x DATA_WIDTH register array, 1 sync write, 1 async read); pointer and counter logic stays in lat_comp_fifo.

Verification (DATA_WIDTH=16, PIPE_LATENCY=3, DEPTH=4)
REQ-029 SHALL cover empty pass-through: in_valid with 0xABCD in cycle n, out_ready=1 -> out_valid=1, out_data=0xABCD in cycle n+1; out_valid=0 in cycle n+2.
REQ-030 SHALL cover credit exhaustion: out_ready=0, issue_fire in 4 consecutive cycles -> issue_ok=0 from the 5th cycle; arrivals 0x0001..0x0004 then drain in order, one per cycle, after out_ready=1.
REQ-031 SHALL cover full simultaneous read/write: occ=4 with in_valid=1 (0x0055) and out_ready=1 -> occ stays 4, ovf_err stays 0, and 0x0055 exits fourth.
REQ-032 SHALL cover overflow: occ=4, out_ready=0, in_valid=1 with 0xDEAD -> data dropped, ovf_err=1 next cycle and held (OVF_EN build).
REQ-033 SHALL cover pointer wrap: 10 items streamed at full rate with out_ready=1 -> output sequence identical to input.
REQ-034 SHALL cover reset mid-stream: reset asserted with occ=2 and infl=1 -> out_valid=0 and issue_ok=1 immediately (asynchronous), and ovf_err=0.
